// File: rtl/canny_edge_chip.sv
`default_nettype none
// ============================================================================
// Module  : canny_edge_chip
// Brief   : Tile edge detector. Loads a 20x20 tile of 5-bit pixels, then
//           streams a 3x3 Sobel |Gx|+|Gy| >= THRESH bit map of the interior.
// Revision: 1.0  initial release
// ============================================================================
module canny_edge_chip #(
    parameter int TILE_W = 20,
    parameter int LANES  = 5,
    parameter int THRESH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] pixel_in0,
    input  logic [4:0] pixel_in1,
    input  logic [4:0] pixel_in2,
    input  logic [4:0] pixel_in3,
    input  logic [4:0] pixel_in4,
    output logic       edge_out,
    input  logic       load_end,
    output logic       readable
);

    localparam int NPIX          = TILE_W * TILE_W;
    localparam int OUT_W         = TILE_W - 2;
    localparam int NOUT          = OUT_W * OUT_W;
    localparam int NBEATS        = NPIX / LANES;
    localparam int BEATS_PER_ROW = TILE_W / LANES;
    localparam int AW            = $clog2(NPIX);
    localparam int BW            = $clog2(NBEATS + 1);
    localparam int OW            = $clog2(NOUT + 1);
    localparam int CW            = $clog2(TILE_W);

    localparam logic [BW-1:0] NBEATS_C  = BW'(NBEATS);
    localparam logic [OW-1:0] NOUT_C    = OW'(NOUT);
    localparam logic [CW-1:0] LAST_COL  = CW'(OUT_W - 1);
    localparam logic [AW-1:0] ROW_SKIP  = AW'(TILE_W - OUT_W + 1);
    localparam logic [8:0]    THRESH_C  = 9'(THRESH);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_OUT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [4:0]      mem [NPIX];
    logic [4:0]      lane [LANES];
    logic [BW-1:0]   beat_cnt;
    logic [OW-1:0]   out_cnt;
    logic [CW-1:0]   col_idx;
    logic [AW-1:0]   win_base;
    logic [AW-1:0]   wr_base;
    logic [4:0]      win [3][3];
    logic [6:0]      sum_r;
    logic [6:0]      sum_l;
    logic [6:0]      sum_b;
    logic [6:0]      sum_t;
    logic signed [8:0] gx;
    logic signed [8:0] gy;
    logic [8:0]      abs_gx;
    logic [8:0]      abs_gy;
    logic [8:0]      mag;
    logic            edge_bit;

    assign lane[0] = pixel_in0;
    assign lane[1] = pixel_in1;
    assign lane[2] = pixel_in2;
    assign lane[3] = pixel_in3;
    assign lane[4] = pixel_in4;

    // Beat k fills row k/4, columns 5*(k%4) .. 5*(k%4)+4.
    assign wr_base = AW'(beat_cnt / BEATS_PER_ROW) * AW'(TILE_W)
                   + AW'(beat_cnt % BEATS_PER_ROW) * AW'(LANES);

    // 1-2-1 weighted tap sum; max 4*31 = 124 fits in 7 bits.
    function automatic logic [6:0] tap121(input logic [4:0] x,
                                          input logic [4:0] y,
                                          input logic [4:0] z);
        return {2'b00, x} + {1'b0, y, 1'b0} + {2'b00, z};
    endfunction

    // win_base is the top-left corner of the current 3x3 window.
    always_comb begin
        for (int a = 0; a < 3; a++) begin
            for (int b = 0; b < 3; b++) begin
                win[a][b] = mem[win_base + AW'(a * TILE_W + b)];
            end
        end
    end

    assign sum_r  = tap121(win[0][2], win[1][2], win[2][2]);
    assign sum_l  = tap121(win[0][0], win[1][0], win[2][0]);
    assign sum_b  = tap121(win[2][0], win[2][1], win[2][2]);
    assign sum_t  = tap121(win[0][0], win[0][1], win[0][2]);
    assign gx     = $signed({2'b00, sum_r}) - $signed({2'b00, sum_l});
    assign gy     = $signed({2'b00, sum_b}) - $signed({2'b00, sum_t});
    assign abs_gx = gx[8] ? $unsigned(-gx) : $unsigned(gx);
    assign abs_gy = gy[8] ? $unsigned(-gy) : $unsigned(gy);
    assign mag    = abs_gx + abs_gy;
    assign edge_bit = (mag >= THRESH_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  if (load_end) state_nxt = S_OUT;
            S_OUT:   if (out_cnt == NOUT_C) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPIX; i++) begin
                mem[i] <= 5'd0;
            end
            beat_cnt <= '0;
            out_cnt  <= '0;
            col_idx  <= '0;
            win_base <= '0;
            readable <= 1'b0;
            edge_out <= 1'b0;
        end else begin
            readable <= 1'b0;
            edge_out <= 1'b0;
            case (state)
                S_LOAD: begin
                    // Beats beyond the last tile beat are dropped; the final
                    // beat is still stored, only the counter freezes.
                    if (beat_cnt < NBEATS_C) begin
                        for (int n = 0; n < LANES; n++) begin
                            mem[wr_base + AW'(n)] <= lane[n];
                        end
                        if (!load_end) begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_cnt < NOUT_C) begin
                        readable <= 1'b1;
                        edge_out <= edge_bit;
                        out_cnt  <= out_cnt + OW'(1);
                        if (col_idx == LAST_COL) begin
                            col_idx  <= '0;
                            win_base <= win_base + ROW_SKIP;
                        end else begin
                            col_idx  <= col_idx + CW'(1);
                            win_base <= win_base + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_canny_edge_chip.sv
`default_nettype none
// ============================================================================
// Module  : tb_canny_edge_chip
// Brief   : Directed bench for canny_edge_chip with a reference Sobel map.
// Revision: 1.0  initial release
// ============================================================================
module tb_canny_edge_chip;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_end;
    logic [4:0] pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4;
    logic       edge_out;
    logic       readable;

    int   img [20][20];
    logic got [324];
    int   n_cmp = 0;
    int   n_bad = 0;

    canny_edge_chip #(.TILE_W(20), .LANES(5), .THRESH(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .pixel_in0(pixel_in0),
        .pixel_in1(pixel_in1),
        .pixel_in2(pixel_in2),
        .pixel_in3(pixel_in3),
        .pixel_in4(pixel_in4),
        .edge_out (edge_out),
        .load_end (load_end),
        .readable (readable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference map: output (i,j) sits on tile pixel (i+1,j+1).
    function automatic logic ref_bit(input int i, input int j);
        int gx, gy, m;
        gx = (img[i][j+2] + 2*img[i+1][j+2] + img[i+2][j+2])
           - (img[i][j]   + 2*img[i+1][j]   + img[i+2][j]);
        gy = (img[i+2][j] + 2*img[i+2][j+1] + img[i+2][j+2])
           - (img[i][j]   + 2*img[i][j+1]   + img[i][j+2]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m >= 64);
    endfunction

    task automatic drive_beat(input int k);
        if (k < 80) begin
            pixel_in0 = 5'(img[k/4][5*(k%4)+0]);
            pixel_in1 = 5'(img[k/4][5*(k%4)+1]);
            pixel_in2 = 5'(img[k/4][5*(k%4)+2]);
            pixel_in3 = 5'(img[k/4][5*(k%4)+3]);
            pixel_in4 = 5'(img[k/4][5*(k%4)+4]);
        end else begin
            pixel_in0 = 5'd31; pixel_in1 = 5'd31; pixel_in2 = 5'd31;
            pixel_in3 = 5'd31; pixel_in4 = 5'd31;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        load_end = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // load_end rides on the last beat and stays high afterwards.
    task automatic load_tile(input string name, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            drive_beat(k);
            load_end = (k == nbeats - 1);
            @(posedge clk); #1;
        end
        chk({name, "_rd_at_capture"}, readable, 0);
    endtask

    task automatic collect(input string name, input int nout);
        for (int k = 0; k < nout; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_rd_k%0d", name, k), readable, 1);
            got[k] = edge_out;
            chk($sformatf("%s_bit_k%0d", name, k), edge_out, ref_bit(k/18, k%18));
        end
    endtask

    task automatic finish_out(input string name);
        @(posedge clk); #1;
        chk({name, "_rd_end"}, readable, 0);
        chk({name, "_edge_end"}, edge_out, 0);
        load_end = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_end = 1'b0;
        pixel_in0 = '0; pixel_in1 = '0; pixel_in2 = '0; pixel_in3 = '0; pixel_in4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readable", readable, 0);
        chk("rst_edge", edge_out, 0);
        reset = 1'b0;

        // Vertical step: columns 10..19 bright; only j=8,9 see it.
        foreach (img[r, c]) img[r][c] = (c >= 10) ? 31 : 0;
        load_tile("vstep", 80);
        collect("vstep", 324);
        finish_out("vstep");
        chk("vstep_5x8", got[5*18+8], 1);
        chk("vstep_5x9", got[5*18+9], 1);
        chk("vstep_5x7", got[5*18+7], 0);
        chk("vstep_5x10", got[5*18+10], 0);

        // DONE ignores beats and load_end.
        for (int k = 0; k < 5; k++) begin
            drive_beat(80);
            load_end = k[0];
            @(posedge clk); #1;
            chk($sformatf("done_rd_%0d", k), readable, 0);
            chk($sformatf("done_edge_%0d", k), edge_out, 0);
        end

        // Uniform 17, ended at beat 78: bright row 19 of the previous tile
        // must not survive the reset.
        do_reset();
        foreach (img[r, c]) img[r][c] = 17;
        load_tile("uni", 79);
        for (int c = 15; c < 20; c++) img[19][c] = 0;
        collect("uni", 324);
        finish_out("uni");
        chk("uni_17x14", got[17*18+14], 1);
        chk("uni_17x13", got[17*18+13], 0);
        chk("uni_16x14", got[16*18+14], 0);
        chk("uni_0x0", got[0], 0);

        // Threshold: column 2 = 16 gives M=64; column 10 alternating 15/16
        // gives M=62 (M is always even, so 62 is the largest value below 64).
        do_reset();
        foreach (img[r, c]) img[r][c] = (c == 2) ? 16 : (c == 10) ? ((r % 2) ? 16 : 15) : 0;
        load_tile("thr", 80);
        collect("thr", 324);
        finish_out("thr");
        chk("thr_m64_j0", got[5*18+0], 1);
        chk("thr_m64_j2", got[5*18+2], 1);
        chk("thr_j1", got[5*18+1], 0);
        chk("thr_m62_j8", got[5*18+8], 0);
        chk("thr_m62_j10", got[6*18+10], 0);

        // Reset landing on output 100, then a fresh load with extra beats.
        do_reset();
        load_tile("abort", 80);
        collect("abort", 100);
        reset = 1'b1;
        load_end = 1'b0;
        @(posedge clk); #1;
        chk("abort_rd", readable, 0);
        chk("abort_edge", edge_out, 0);
        reset = 1'b0;
        foreach (img[r, c]) img[r][c] = (r >= 10) ? 31 : 0;
        load_tile("hstep", 82);
        collect("hstep", 324);
        finish_out("hstep");
        chk("hstep_8x5", got[8*18+5], 1);
        chk("hstep_9x5", got[9*18+5], 1);
        chk("hstep_7x5", got[7*18+5], 0);
        chk("hstep_10x5", got[10*18+5], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
